uncached_store_buffer: RTL and testbench
========================================

# uncached_store_buffer

Posted-write buffer between the core's SRAM-like data port and the data port of the AXI cache/adapter. Uncached stores (MMIO, confreg, UART) are acknowledged to the core one cycle after acceptance and drained to the adapter in order. All other requests pass through. Reads and cached accesses wait until the buffer has fully drained, so memory ordering stays strict.

## Interface
- `DEPTH`, 4: number of buffered stores; must be a power of two and at least 2.
- `PASS_MAX`, 7: maximum number of outstanding pass-through requests; the counter is 3 bits wide.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous reset, active low.
- `cpu_req` in 1: request from the core; held high until `cpu_addr_ok`.
- `cpu_wr` in 1: 1 = write.
- `cpu_size` in 2: 0 = byte, 1 = half, 2 = word.
- `cpu_addr` in 32: physical address.
- `cpu_wdata` in 32: write data.
- `cpu_uncached` in 1: uncached attribute.
- `cpu_addr_ok` out 1: request accepted this cycle.
- `cpu_data_ok` out 1: one pulse per accepted request, in acceptance order.
- `cpu_rdata` out 32: read data, valid with `cpu_data_ok` for reads.
- `mem_req`, `mem_wr`, `mem_size`, `mem_addr`, `mem_wdata`, `mem_uncached` out 1/1/2/32/32/1: request to the adapter.
- `mem_addr_ok` in 1: adapter accepted the request.
- `mem_data_ok` in 1: adapter completion.
- `mem_rdata` in 32: adapter read data.

## Operation
- A handshake completes when req && addr_ok in the same cycle, on both sides. The responding side does not depend combinationally on its own `*_data_ok`.
- Bufferable request: `cpu_wr` && `cpu_uncached`.
- Buffered write accept:
  - Condition: FIFO not full && `pass_cnt` == 0.
  - `cpu_addr_ok` = 1 combinationally.
  - The entry {addr, size, wdata} is pushed.
  - `ack_q` is set; `cpu_data_ok` = `ack_q` in the next cycle.
- Drain:
  - While the FIFO is not empty, `mem_req` = 1 and the mem fields come from the FIFO head, with `mem_wr` = 1 and `mem_uncached` = 1.
  - On `mem_addr_ok` the head is popped and `drain_cnt` increments.
  - On `mem_data_ok` while `drain_cnt` > 0, `drain_cnt` decrements; this completion is not forwarded to the core.
- Pass-through (non-bufferable request):
  - Allowed only when FIFO empty && `drain_cnt` == 0 && `ack_q` == 0 && `pass_cnt` < `PASS_MAX`.
  - The mem fields mirror the cpu fields.
  - `cpu_addr_ok` = `mem_addr_ok`.
  - `pass_cnt` increments on the handshake.
  - `cpu_data_ok` = `mem_data_ok` while `pass_cnt` > 0; `pass_cnt` decrements on that pulse.
  - `cpu_rdata` = `mem_rdata` always.
- Arbitration: a non-empty FIFO owns the mem port. A pass-through request is held with `cpu_addr_ok` = 0 until the drain has fully completed.
- Simultaneous push and pop: both take effect. The count is unchanged and a write is accepted even when the FIFO is full.
- Simultaneous increment and decrement of `pass_cnt` or `drain_cnt`: the counter is unchanged.
- Pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`. Full/empty is tracked with a separate count of log2(`DEPTH`)+1 bits.
- Reset mid-operation: the FIFO contents are discarded, all counters clear and no `data_ok` is produced for lost entries. The core is reset at the same time.

## Timing
- Reset values:
  - `cpu_addr_ok` = 0, `cpu_data_ok` = 0, `mem_req` = 0.
  - `mem_wr`, `mem_size`, `mem_addr`, `mem_wdata`, `mem_uncached` = 0.
  - `cpu_rdata` = `mem_rdata`.
  - `ack_q` = 0, FIFO empty, `pass_cnt` = 0, `drain_cnt` = 0.
- Buffered write:
  - `cpu_addr_ok` in the accept cycle T; `cpu_data_ok` at T+1.
  - Earliest `mem_req` for that entry at T+1; the push is registered.
- Pass-through adds zero cycles of latency to requests and responses.
- Back-to-back buffered writes are accepted one per cycle until the FIFO is full.
- `ack_q` and pass-through `cpu_data_ok` can never be high in the same cycle. The pass-through gating above guarantees this; the bench asserts it.

## Test plan
- Buffered store:
  - Stimulus: sw to 0xBFAFF000, data 0x12345678, `cpu_size` = 2; `mem_addr_ok` held 1.
  - Required: `cpu_addr_ok` at T and `cpu_data_ok` at T+1.
  - Required: `mem_req` at T+1 with the same addr/data/size; `mem_data_ok` is not forwarded.
- Full FIFO:
  - Stimulus: 5 uncached writes (0x1, 0x2, 0x3, 0x4, 0x5) back to back with `mem_addr_ok` = 0.
  - Required: 4 accepted and the 5th stalled. The 5th is accepted in the same cycle as the first `mem_addr_ok`; the drain order is 1..5.
- Read after writes:
  - Stimulus: 2 buffered writes, then an uncached lw to 0xBFAF8000.
  - Required: the lw is held until the 2nd drain `mem_data_ok`, then forwarded.
  - Required: `cpu_rdata` = 0xCAFEBABE with `cpu_data_ok`.
- Write behind reads:
  - Stimulus: 3 pipelined cached reads outstanding, then an uncached sw.
  - Required: sw `cpu_addr_ok` = 0 until `pass_cnt` reaches 0; the 3 read `data_ok`s precede the sw `data_ok`.
- Pass-through limit:
  - Stimulus: 8 cached reads with `mem_data_ok` held low.
  - Required: only 7 accepted; the 8th is accepted after one `mem_data_ok`.
- Reset mid-drain:
  - Stimulus: 3 entries buffered, `aresetn` = 0 for 1 cycle.
  - Required: `mem_req` = 0 immediately; no `cpu_data_ok`; the next write behaves as in the buffered-store scenario.

Source files
------------

// File: rtl/uncached_store_buffer.sv
// Posted-write buffer between the core data port and the AXI adapter data port.
// Uncached stores are acknowledged one cycle after acceptance and drained in
// order. All other requests pass through once the buffer has fully drained.
module uncached_store_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PASS_MAX = 7
) (
  input  logic        aclk,
  input  logic        aresetn,
  // core side
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_uncached,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  // adapter side
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_uncached,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned DCW = 4;

  // FIFO storage (contents need no reset; pointers and count define validity)
  logic [31:0]   fifo_addr_q  [DEPTH];
  logic [31:0]   fifo_wdata_q [DEPTH];
  logic [1:0]    fifo_size_q  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic [2:0]    pass_cnt_q, pass_cnt_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;

  logic bufferable;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic pass_ok;
  logic pass_req;
  logic pass_hs;
  logic pass_done;
  logic drain_done;

  // Request classification, arbitration and handshakes
  always_comb begin
    bufferable = cpu_wr & cpu_uncached;
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == CW'(DEPTH));
    pop        = ~fifo_empty & mem_addr_ok;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push       = cpu_req & bufferable & (pass_cnt_q == '0) & (~fifo_full | pop);
    // Pass-through only once every buffered store has completed and its ack
    // has been delivered, so ack_q and a forwarded data_ok never collide.
    pass_ok    = fifo_empty & (drain_cnt_q == '0) & ~ack_q &
                 (pass_cnt_q < 3'(PASS_MAX));
    pass_req   = cpu_req & ~bufferable & pass_ok;
    pass_hs    = pass_req & mem_addr_ok;
    pass_done  = (pass_cnt_q != '0) & mem_data_ok;
    drain_done = (drain_cnt_q != '0) & mem_data_ok;
  end

  // Core-side responses
  always_comb begin
    cpu_addr_ok = push | pass_hs;
    cpu_data_ok = ack_q | pass_done;
    cpu_rdata   = mem_rdata;
  end

  // Adapter-side request mux: FIFO head has priority over pass-through
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_uncached = 1'b0;
    if (!fifo_empty) begin
      mem_req      = 1'b1;
      mem_wr       = 1'b1;
      mem_size     = fifo_size_q[rd_ptr_q];
      mem_addr     = fifo_addr_q[rd_ptr_q];
      mem_wdata    = fifo_wdata_q[rd_ptr_q];
      mem_uncached = 1'b1;
    end else if (pass_req) begin
      mem_req      = 1'b1;
      mem_wr       = cpu_wr;
      mem_size     = cpu_size;
      mem_addr     = cpu_addr;
      mem_wdata    = cpu_wdata;
      mem_uncached = cpu_uncached;
    end
  end

  // Next-state for pointers, occupancy and outstanding-transaction counters
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    ack_d       = push;
    pass_cnt_d  = pass_cnt_q;
    drain_cnt_d = drain_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);

    if (pass_hs && !pass_done)      pass_cnt_d = pass_cnt_q + 3'd1;
    else if (!pass_hs && pass_done) pass_cnt_d = pass_cnt_q - 3'd1;

    if (pop && !drain_done)      drain_cnt_d = drain_cnt_q + DCW'(1);
    else if (!pop && drain_done) drain_cnt_d = drain_cnt_q - DCW'(1);
  end

  // Control state registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      pass_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      pass_cnt_q  <= pass_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // FIFO entry write on accepted buffered store
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= cpu_addr;
      fifo_wdata_q[wr_ptr_q] <= cpu_wdata;
      fifo_size_q[wr_ptr_q]  <= cpu_size;
    end
  end

endmodule

// File: tb/tb_uncached_store_buffer.sv
// Directed bench for uncached_store_buffer; the bench plays both the core and
// the adapter and checks every handshake cycle against hand-derived values.
module tb_uncached_store_buffer;

  logic        aclk;
  logic        aresetn;
  logic        cpu_req, cpu_wr, cpu_uncached;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_wr, mem_uncached;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  uncached_store_buffer #(.DEPTH(4), .PASS_MAX(7)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_uncached(cpu_uncached),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_uncached(mem_uncached),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // A buffered-store ack and a forwarded completion must never coincide.
  always @(negedge aclk) begin
    if (aresetn) begin
      assert (!(dut.ack_q && dut.pass_cnt_q != 3'd0 && mem_data_ok))
        else $error("FAIL ack_overlap: ack_q and pass data_ok both high");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cpu_drive(input logic wr, input logic unc, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req      = 1'b1;
    cpu_wr       = wr;
    cpu_uncached = unc;
    cpu_size     = sz;
    cpu_addr     = addr;
    cpu_wdata    = wdata;
  endtask

  task automatic cpu_idle();
    cpu_req      = 1'b0;
    cpu_wr       = 1'b0;
    cpu_uncached = 1'b0;
    cpu_size     = 2'd0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
  endtask

  // Single sw to the confreg window with the adapter always ready
  task automatic store_scenario(input string p);
    cpu_drive(1'b1, 1'b1, 2'd2, 32'hBFAF_F000, 32'h1234_5678);
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b0;
    settle();
    check_eq({p, "_addr_ok_T"},  cpu_addr_ok, 1);
    check_eq({p, "_data_ok_T"},  cpu_data_ok, 0);
    check_eq({p, "_mem_req_T"},  mem_req, 0);
    tick();
    cpu_idle();
    settle();
    check_eq({p, "_data_ok_T1"}, cpu_data_ok, 1);
    check_eq({p, "_addr_ok_T1"}, cpu_addr_ok, 0);
    check_eq({p, "_mem_req_T1"}, mem_req, 1);
    check_eq({p, "_mem_addr"},   mem_addr, 32'hBFAF_F000);
    check_eq({p, "_mem_wdata"},  mem_wdata, 32'h1234_5678);
    check_eq({p, "_mem_size"},   mem_size, 2);
    check_eq({p, "_mem_wr"},     mem_wr, 1);
    check_eq({p, "_mem_unc"},    mem_uncached, 1);
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    settle();
    check_eq({p, "_no_fwd"},     cpu_data_ok, 0);
    check_eq({p, "_mem_req_T2"}, mem_req, 0);
    tick();
    mem_data_ok = 1'b0;
  endtask

  initial begin
    aresetn     = 1'b0;
    cpu_idle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'hDEAD_BEEF;

    // ---------------- reset state
    tick(); tick();
    check_eq("rst_addr_ok", cpu_addr_ok, 0);
    check_eq("rst_data_ok", cpu_data_ok, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_wr",  mem_wr, 0);
    check_eq("rst_mem_size", mem_size, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_mem_unc", mem_uncached, 0);
    check_eq("rst_rdata",   cpu_rdata, 32'hDEAD_BEEF);
    aresetn = 1'b1;
    tick();

    // ---------------- buffered store
    store_scenario("st");

    // ---------------- full FIFO: five stores, adapter stalled
    mem_addr_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_drive(1'b1, 1'b1, 2'd2, 32'hBFAF_0010 + 32'(i * 4), 32'(i + 1));
      settle();
      check_eq($sformatf("full_addr_ok_%0d", i), cpu_addr_ok, (i < 4) ? 1 : 0);
      check_eq($sformatf("full_data_ok_%0d", i), cpu_data_ok, (i > 0) ? 1 : 0);
      tick();
    end
    settle();
    check_eq("full_hold_addr_ok", cpu_addr_ok, 0);
    check_eq("full_hold_data_ok", cpu_data_ok, 0);
    check_eq("full_hold_head",    mem_wdata, 1);
    tick();
    mem_addr_ok = 1'b1;
    settle();
    check_eq("full_pop_push_ok", cpu_addr_ok, 1);
    check_eq("full_drain_0",     mem_wdata, 1);
    tick();
    cpu_idle();
    settle();
    check_eq("full_ack5", cpu_data_ok, 1);
    for (int i = 1; i < 5; i++) begin
      settle();
      check_eq($sformatf("full_drain_%0d", i), mem_wdata, 32'(i + 1));
      check_eq($sformatf("full_drain_addr_%0d", i), mem_addr, 32'hBFAF_0010 + 32'(i * 4));
      tick();
    end
    mem_addr_ok = 1'b0;
    settle();
    check_eq("full_empty_req", mem_req, 0);
    for (int i = 0; i < 5; i++) begin
      mem_data_ok = 1'b1;
      settle();
      check_eq($sformatf("full_no_fwd_%0d", i), cpu_data_ok, 0);
      tick();
    end
    mem_data_ok = 1'b0;
    tick();

    // ---------------- read after writes
    mem_addr_ok = 1'b0;
    cpu_drive(1'b1, 1'b1, 2'd2, 32'hBFAF_0100, 32'h0000_00A1);
    settle();
    check_eq("raw_w1_ok", cpu_addr_ok, 1);
    tick();
    cpu_drive(1'b1, 1'b1, 2'd2, 32'hBFAF_0104, 32'h0000_00B2);
    settle();
    check_eq("raw_w2_ok", cpu_addr_ok, 1);
    tick();
    cpu_drive(1'b0, 1'b1, 2'd2, 32'hBFAF_8000, 32'h0);
    mem_addr_ok = 1'b1;
    settle();
    check_eq("raw_lw_hold0", cpu_addr_ok, 0);
    check_eq("raw_ack_w2",   cpu_data_ok, 1);
    check_eq("raw_drain_a0", mem_addr, 32'hBFAF_0100);
    tick();
    settle();
    check_eq("raw_lw_hold1", cpu_addr_ok, 0);
    check_eq("raw_drain_a1", mem_addr, 32'hBFAF_0104);
    tick();
    mem_data_ok = 1'b1;
    settle();
    check_eq("raw_lw_hold2", cpu_addr_ok, 0);
    check_eq("raw_req_hold2", mem_req, 0);
    check_eq("raw_no_fwd1",  cpu_data_ok, 0);
    tick();
    settle();
    check_eq("raw_lw_hold3", cpu_addr_ok, 0);
    check_eq("raw_no_fwd2",  cpu_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;
    settle();
    check_eq("raw_lw_ok",   cpu_addr_ok, 1);
    check_eq("raw_lw_req",  mem_req, 1);
    check_eq("raw_lw_wr",   mem_wr, 0);
    check_eq("raw_lw_addr", mem_addr, 32'hBFAF_8000);
    check_eq("raw_lw_unc",  mem_uncached, 1);
    tick();
    cpu_idle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hCAFE_BABE;
    settle();
    check_eq("raw_lw_data_ok", cpu_data_ok, 1);
    check_eq("raw_lw_rdata",   cpu_rdata, 32'hCAFE_BABE);
    tick();
    mem_data_ok = 1'b0;
    settle();
    check_eq("raw_idle_data_ok", cpu_data_ok, 0);
    tick();

    // ---------------- write behind reads
    mem_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_drive(1'b0, 1'b0, 2'd2, 32'h0000_1000 + 32'(i * 4), 32'h0);
      settle();
      check_eq($sformatf("wbr_rd_ok_%0d", i), cpu_addr_ok, 1);
      check_eq($sformatf("wbr_rd_unc_%0d", i), mem_uncached, 0);
      tick();
    end
    cpu_drive(1'b1, 1'b1, 2'd2, 32'hBFAF_0200, 32'h0000_0055);
    mem_data_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rdata = 32'h5000_0000 + 32'(i);
      settle();
      check_eq($sformatf("wbr_sw_hold_%0d", i), cpu_addr_ok, 0);
      check_eq($sformatf("wbr_rd_dok_%0d", i), cpu_data_ok, 1);
      check_eq($sformatf("wbr_rd_data_%0d", i), cpu_rdata, 32'h5000_0000 + 32'(i));
      check_eq($sformatf("wbr_req_%0d", i), mem_req, 0);
      tick();
    end
    mem_data_ok = 1'b0;
    settle();
    check_eq("wbr_sw_ok",   cpu_addr_ok, 1);
    check_eq("wbr_sw_dok0", cpu_data_ok, 0);
    tick();
    cpu_idle();
    settle();
    check_eq("wbr_sw_ack",  cpu_data_ok, 1);
    check_eq("wbr_sw_addr", mem_addr, 32'hBFAF_0200);
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    settle();
    check_eq("wbr_sw_no_fwd", cpu_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;
    tick();

    // ---------------- pass-through limit
    mem_addr_ok = 1'b1;
    cpu_drive(1'b0, 1'b0, 2'd2, 32'h0000_2000, 32'h0);
    for (int i = 0; i < 7; i++) begin
      settle();
      check_eq($sformatf("lim_ok_%0d", i), cpu_addr_ok, 1);
      tick();
    end
    settle();
    check_eq("lim_8th_hold", cpu_addr_ok, 0);
    check_eq("lim_8th_req",  mem_req, 0);
    tick();
    mem_data_ok = 1'b1;
    settle();
    check_eq("lim_8th_hold2", cpu_addr_ok, 0);
    check_eq("lim_dok_first", cpu_data_ok, 1);
    tick();
    mem_data_ok = 1'b0;
    settle();
    check_eq("lim_8th_ok", cpu_addr_ok, 1);
    tick();
    cpu_idle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      settle();
      check_eq($sformatf("lim_dok_%0d", i), cpu_data_ok, 1);
      tick();
    end
    settle();
    check_eq("lim_spurious", cpu_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;
    tick();

    // ---------------- reset mid-drain
    mem_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_drive(1'b1, 1'b1, 2'd2, 32'hBFAF_0300 + 32'(i * 4), 32'h0000_0070 + 32'(i));
      settle();
      check_eq($sformatf("rmd_ok_%0d", i), cpu_addr_ok, 1);
      tick();
    end
    cpu_idle();
    settle();
    check_eq("rmd_pre_req", mem_req, 1);
    check_eq("rmd_pre_dok", cpu_data_ok, 1);
    aresetn = 1'b0;
    settle();
    check_eq("rmd_req_now", mem_req, 0);
    check_eq("rmd_dok_now", cpu_data_ok, 0);
    tick();
    aresetn = 1'b1;
    mem_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq($sformatf("rmd_after_req_%0d", i), mem_req, 0);
      check_eq($sformatf("rmd_after_dok_%0d", i), cpu_data_ok, 0);
      tick();
    end
    store_scenario("rst_st");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
